// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - KxK sliding-window generator over circular line buffers
// Buffers K+STRIDE image rows; emits one registered window per cycle with full backpressure.
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int STRIDE = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_start,
    input  logic                    i_pix_valid,
    output logic                    o_pix_ready,
    input  logic [DATA_W-1:0]       i_pix,
    output logic                    o_win_valid,
    input  logic                    i_win_ready,
    output logic [K*K*DATA_W-1:0]   o_win,
    output logic                    o_win_row_start,
    output logic                    o_win_row_end,
    output logic                    o_win_last,
    output logic                    o_done,
    output logic                    o_busy
);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int NBUF  = K + STRIDE;
    localparam int CW    = $clog2(IMG_W) + 1;
    localparam int RW    = $clog2(IMG_H) + 1;
    localparam int BW    = $clog2(NBUF) + 1;
    localparam int OCW   = $clog2(OUT_W) + 1;
    localparam int ORW   = $clog2(OUT_H) + 1;
    localparam int PW    = $clog2(STRIDE) + 1;
    localparam int CI    = $clog2(IMG_W);
    localparam int BI    = $clog2(NBUF);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    wr_col_q, wr_col_d;
    logic [RW-1:0]    in_row_q, in_row_d;
    logic [BW-1:0]    wr_buf_q, wr_buf_d;
    logic [BW-1:0]    base_q, base_d, base_inc;
    logic [OCW-1:0]   out_col_q, out_col_d;
    logic [ORW-1:0]   out_row_q, out_row_d;
    logic [PW-1:0]    pf_q, pf_d, pf_next;

    logic [DATA_W-1:0] lb_q [NBUF][IMG_W];

    logic                  win_valid_q, row_start_q, row_end_q, last_q;
    logic [K*K*DATA_W-1:0] win_q, win_d;

    logic pix_ready, pix_xfer, row_done, fill_done, load_ok, emit, row_end_emit, rotate;

    always_comb begin
        pix_ready = 1'b0;
        case (state_q)
            S_FILL:  pix_ready = 1'b1;
            // The final output row needs no prefetch; leftover rows are drained instead.
            S_RUN:   pix_ready = (pf_q < PW'(STRIDE)) && (out_row_q != ORW'(OUT_H - 1))
                                 && (in_row_q < RW'(IMG_H));
            S_WAIT:  pix_ready = (pf_q < PW'(STRIDE));
            S_DRAIN: pix_ready = (in_row_q < RW'(IMG_H));
            default: pix_ready = 1'b0;
        endcase
    end

    assign pix_xfer  = i_pix_valid && pix_ready;
    assign row_done  = pix_xfer && (wr_col_q == CW'(IMG_W - 1));
    assign fill_done = (state_q == S_FILL) && row_done && (in_row_q == RW'(K - 1));
    assign load_ok   = !win_valid_q || i_win_ready;
    // The first window can leave on the fill-completing cycle since it never reads the last column.
    assign emit      = load_ok && ((state_q == S_RUN) || (fill_done && (K < IMG_W)));
    assign row_end_emit = emit && (out_col_q == OCW'(OUT_W - 1));
    assign pf_next   = pf_q + PW'(((state_q == S_RUN) || (state_q == S_WAIT)) && row_done);
    assign base_inc  = base_q + BW'(STRIDE);

    always_comb begin
        state_d   = state_q;
        wr_col_d  = wr_col_q;
        in_row_d  = in_row_q;
        wr_buf_d  = wr_buf_q;
        base_d    = base_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        pf_d      = pf_q;
        rotate    = 1'b0;

        if (row_done) begin
            wr_col_d = '0;
            in_row_d = in_row_q + RW'(1);
            wr_buf_d = (wr_buf_q == BW'(NBUF - 1)) ? '0 : wr_buf_q + BW'(1);
        end else if (pix_xfer) begin
            wr_col_d = wr_col_q + CW'(1);
        end
        if ((state_q == S_RUN) || (state_q == S_WAIT)) pf_d = pf_next;
        if (emit) out_col_d = row_end_emit ? '0 : out_col_q + OCW'(1);

        case (state_q)
            S_IDLE: if (i_start) begin
                state_d   = S_FILL;
                wr_col_d  = '0;
                in_row_d  = '0;
                wr_buf_d  = '0;
                base_d    = '0;
                out_col_d = '0;
                out_row_d = '0;
                pf_d      = '0;
            end
            S_FILL:  if (fill_done) state_d = S_RUN;
            S_WAIT:  if (pf_next == PW'(STRIDE)) rotate = 1'b1;
            S_DRAIN: if (in_row_d == RW'(IMG_H)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        if (row_end_emit) begin
            if (out_row_q == ORW'(OUT_H - 1))  state_d = S_DRAIN;
            else if (pf_next == PW'(STRIDE))   rotate  = 1'b1;
            else                               state_d = S_WAIT;
        end
        if (rotate) begin
            state_d   = S_RUN;
            base_d    = (base_inc >= BW'(NBUF)) ? base_inc - BW'(NBUF) : base_inc;
            out_row_d = out_row_q + ORW'(1);
            pf_d      = '0;
        end
    end

    always_comb begin
        int bi;
        int ci;
        win_d = '0;
        bi    = 0;
        ci    = 0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                bi = int'(base_q) + r;
                if (bi >= NBUF) bi = bi - NBUF;
                ci = int'(out_col_q) * STRIDE + c;
                win_d[(r*K+c)*DATA_W +: DATA_W] = lb_q[BI'(bi)][CI'(ci)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wr_col_q  <= '0;
            in_row_q  <= '0;
            wr_buf_q  <= '0;
            base_q    <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            pf_q      <= '0;
        end else begin
            state_q   <= state_d;
            wr_col_q  <= wr_col_d;
            in_row_q  <= in_row_d;
            wr_buf_q  <= wr_buf_d;
            base_q    <= base_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            pf_q      <= pf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && pix_xfer && (state_q != S_DRAIN))
            lb_q[wr_buf_q[BI-1:0]][wr_col_q[CI-1:0]] <= i_pix;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win_valid_q <= 1'b0;
            win_q       <= '0;
            row_start_q <= 1'b0;
            row_end_q   <= 1'b0;
            last_q      <= 1'b0;
        end else if (load_ok) begin
            win_valid_q <= emit;
            if (emit) begin
                win_q       <= win_d;
                row_start_q <= (out_col_q == '0);
                row_end_q   <= row_end_emit;
                last_q      <= row_end_emit && (out_row_q == ORW'(OUT_H - 1));
            end
        end
    end

    assign o_pix_ready     = pix_ready;
    assign o_win_valid     = win_valid_q;
    assign o_win           = win_q;
    assign o_win_row_start = row_start_q;
    assign o_win_row_end   = row_end_q;
    assign o_win_last      = last_q;
    assign o_done          = (state_q == S_DONE);
    assign o_busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - randomized bench for conv_window_gen against a window reference model
// Two instances: 32x32 K=5 S=1 and 8x8 K=3 S=2; a selector routes the shared stimulus.
module tb_conv_window_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start;
    logic       pix_valid;
    logic [7:0] pix;
    logic       win_ready;
    int         sel;

    logic         pix_ready_a, win_valid_a, rs_a, re_a, last_a, done_a, busy_a;
    logic [199:0] win_a;
    logic         pix_ready_b, win_valid_b, rs_b, re_b, last_b, done_b, busy_b;
    logic [71:0]  win_b;

    conv_window_gen #(.DATA_W(8), .IMG_W(32), .IMG_H(32), .K(5), .STRIDE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_start(start && sel == 0),
        .i_pix_valid(pix_valid), .o_pix_ready(pix_ready_a), .i_pix(pix),
        .o_win_valid(win_valid_a), .i_win_ready(win_ready), .o_win(win_a),
        .o_win_row_start(rs_a), .o_win_row_end(re_a), .o_win_last(last_a),
        .o_done(done_a), .o_busy(busy_a)
    );

    conv_window_gen #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_start(start && sel == 1),
        .i_pix_valid(pix_valid), .o_pix_ready(pix_ready_b), .i_pix(pix),
        .o_win_valid(win_valid_b), .i_win_ready(win_ready), .o_win(win_b),
        .o_win_row_start(rs_b), .o_win_row_end(re_b), .o_win_last(last_b),
        .o_done(done_b), .o_busy(busy_b)
    );

    logic         m_pix_ready, m_win_valid, m_rs, m_re, m_last, m_done, m_busy;
    logic [199:0] m_win;
    always_comb begin
        if (sel == 0) begin
            {m_pix_ready, m_win_valid, m_rs, m_re, m_last, m_done, m_busy} =
                {pix_ready_a, win_valid_a, rs_a, re_a, last_a, done_a, busy_a};
            m_win = win_a;
        end else begin
            {m_pix_ready, m_win_valid, m_rs, m_re, m_last, m_done, m_busy} =
                {pix_ready_b, win_valid_b, rs_b, re_b, last_b, done_b, busy_b};
            m_win = {128'b0, win_b};
        end
    end

    int tests = 0;
    int fails = 0;
    int k, w, h, s;
    logic [7:0] img [1024];

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window n of the frame, taken straight from the stored image.
    function automatic logic [199:0] exp_win(input int n);
        logic [199:0] v;
        int ow, orow, ocol;
        v    = '0;
        ow   = (w - k) / s + 1;
        orow = n / ow;
        ocol = n % ow;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                v[(r*k+c)*8 +: 8] = img[(orow*s + r)*w + ocol*s + c];
        return v;
    endfunction

    task automatic run_frame(input int sl, input bit pat, input int vpct, input int rpct,
                             input int abort_win, input bit poke);
        int ow, oh, nwin, pix_idx, win_idx, done_cnt, fill_cyc, first_cyc, cyc;
        bit fin, aborted, poked;
        sel = sl;
        if (sl == 0) begin k = 5; w = 32; h = 32; s = 1; end
        else         begin k = 3; w = 8;  h = 8;  s = 2; end
        for (int i = 0; i < w*h; i++) img[i] = pat ? 8'(i) : 8'($urandom);
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        nwin = ow * oh;
        pix_idx = 0; win_idx = 0; done_cnt = 0; fill_cyc = -1; first_cyc = -1;
        fin = 0; aborted = 0; poked = 0;

        start = 1'b1; pix_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 0; cyc < 20000 && !fin && !aborted; cyc++) begin
            pix_valid = (pix_idx < w*h) && ($urandom_range(99) < 32'(vpct));
            pix       = (pix_idx < w*h) ? img[pix_idx] : 8'h00;
            win_ready = ($urandom_range(99) < 32'(rpct));
            start     = poke && !poked && (win_idx >= nwin/2);
            if (start) poked = 1;
            @(negedge clk);
            if (m_win_valid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check("first_window_latency", 200'(cyc), 200'(fill_cyc + 1));
                end
                if (win_idx < nwin) begin
                    check("window_data", m_win, exp_win(win_idx));
                    check("window_flags", 200'({m_rs, m_re, m_last}),
                          200'({win_idx % ow == 0, win_idx % ow == ow - 1, win_idx == nwin - 1}));
                end else begin
                    check("extra_window", 200'(win_idx), 200'(nwin - 1));
                end
                if (win_ready) win_idx++;
            end
            if (pix_valid && m_pix_ready) begin
                if (pix_idx == k*w - 1) fill_cyc = cyc;
                pix_idx++;
            end
            if (m_done) begin
                done_cnt++;
                check("done_after_all_pixels", 200'(pix_idx), 200'(w*h));
            end
            if (done_cnt > 0 && win_idx == nwin) fin = 1;
            if (abort_win >= 0 && win_idx >= abort_win) aborted = 1;
            @(posedge clk); #1;
        end
        start = 1'b0;

        if (aborted) begin
            reset_n = 1'b0; pix_valid = 1'b0; win_ready = 1'b0;
            @(posedge clk); #1;
            check("abort_outputs_zero",
                  200'({m_pix_ready, m_win_valid, m_rs, m_re, m_last, m_done, m_busy}), 200'(0));
            check("abort_window_zero", m_win, 200'(0));
            reset_n = 1'b1;
            @(posedge clk); #1;
        end else begin
            check("frame_finished_in_budget", 200'(fin), 200'(1));
            pix_valid = 1'b0; win_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (m_done) done_cnt++;
                if (m_win_valid) win_idx++;
            end
            check("window_count", 200'(win_idx), 200'(nwin));
            check("pixel_count", 200'(pix_idx), 200'(w*h));
            check("done_pulses", 200'(done_cnt), 200'(1));
            check("idle_after_frame", 200'({m_busy, m_win_valid, m_pix_ready}), 200'(0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix = 8'h00; win_ready = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_a",
              200'({pix_ready_a, win_valid_a, rs_a, re_a, last_a, done_a, busy_a}), 200'(0));
        check("reset_window_a", win_a, 200'(0));
        check("reset_outputs_b",
              200'({pix_ready_b, win_valid_b, rs_b, re_b, last_b, done_b, busy_b}), 200'(0));
        check("reset_window_b", 200'(win_b), 200'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_frame(0, 1'b1, 100, 100, -1, 1'b0);
        run_frame(0, 1'b1, 100, 70,  -1, 1'b0);
        run_frame(0, 1'b1, 50,  100, -1, 1'b0);
        run_frame(1, 1'b1, 100, 100, -1, 1'b0);
        run_frame(1, 1'b0, 60,  60,  -1, 1'b0);
        run_frame(0, 1'b1, 100, 100, 10*28, 1'b0);
        run_frame(0, 1'b1, 100, 100, -1, 1'b0);
        run_frame(0, 1'b1, 100, 100, -1, 1'b1);
        run_frame(0, 1'b0, 70,  70,  -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
